// File: rtl/yuv_rgb_pkg.sv
// -----------------------------------------------------------------------------
// yuv_rgb_pkg
// Shared constants and helpers for the YUV422 -> RGB converter.
//   - component width, chroma offset, rounding constant and shift
//   - BT.601 and BT.709 full-swing coefficient sets. K_* selects the active
//     set: BT.709 when YUV422_TO_RGB_BT709_EN is defined, BT.601 otherwise.
//   - clamp_u8: saturates a signed sum to an unsigned 8-bit component
// No ports (package).
// -----------------------------------------------------------------------------
package yuv_rgb_pkg;

    localparam int COMP_W     = 8;
    localparam int CHROMA_OFS = 128;
    localparam int ROUND      = 128;
    localparam int SHIFT      = 8;

    localparam logic signed [17:0] K601_RV = 18'sd359;
    localparam logic signed [17:0] K601_GU = 18'sd88;
    localparam logic signed [17:0] K601_GV = 18'sd183;
    localparam logic signed [17:0] K601_BU = 18'sd454;

    localparam logic signed [17:0] K709_RV = 18'sd403;
    localparam logic signed [17:0] K709_GU = 18'sd48;
    localparam logic signed [17:0] K709_GV = 18'sd120;
    localparam logic signed [17:0] K709_BU = 18'sd475;

`ifdef YUV422_TO_RGB_BT709_EN
    localparam logic signed [17:0] K_RV = K709_RV;
    localparam logic signed [17:0] K_GU = K709_GU;
    localparam logic signed [17:0] K_GV = K709_GV;
    localparam logic signed [17:0] K_BU = K709_BU;
`else
    localparam logic signed [17:0] K_RV = K601_RV;
    localparam logic signed [17:0] K_GU = K601_GU;
    localparam logic signed [17:0] K_GV = K601_GV;
    localparam logic signed [17:0] K_BU = K601_BU;
`endif

    function automatic logic [COMP_W-1:0] clamp_u8(input logic signed [17:0] x);
        if (x < 18'sd0)
            return '0;
        else if (x > 18'sd255)
            return '1;
        else
            return x[COMP_W-1:0];
    endfunction

endpackage

// File: rtl/yuv_pair_to_rgb.sv
// -----------------------------------------------------------------------------
// yuv_pair_to_rgb
// Converts one {Y0,U,Y1,V} pair into two RGB pixels through three registered
// stages: S1 centres chroma, S2 forms the coefficient products, S3 rounds,
// adds luma and clamps. Stage loading is controlled by the caller.
// Coefficient set follows YUV422_TO_RGB_BT709_EN (see yuv_rgb_pkg).
// Ports:
//   clk_i        clock
//   reset_i      asynchronous active-high reset
//   stage_en_i   [0]=load S1, [1]=load S2, [2]=load S3
//   yuv_i        {Y0,U,Y1,V}, 8 bits each, MSB first
//   rgb_o        {R0,G0,B0,R1,G1,B1}, S3 output register
// -----------------------------------------------------------------------------
module yuv_pair_to_rgb
    import yuv_rgb_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [2:0]  stage_en_i,
    input  logic [31:0] yuv_i,
    output logic [47:0] rgb_o
);

    localparam logic signed [8:0]  OFS9  = 9'(CHROMA_OFS);
    localparam logic signed [17:0] RND18 = 18'(ROUND);

    logic [7:0]         s1_y0_q, s1_y1_q;
    logic signed [8:0]  s1_u_q, s1_v_q, s1_u_d, s1_v_d;

    logic [7:0]         s2_y0_q, s2_y1_q;
    logic signed [17:0] s2_pr_q, s2_pgu_q, s2_pgv_q, s2_pb_q;
    logic signed [17:0] s2_pr_d, s2_pgu_d, s2_pgv_d, s2_pb_d;
    logic signed [17:0] u_ext, v_ext;

    logic signed [17:0] r_off, g_off, b_off, y0_ext, y1_ext;
    logic [47:0]        rgb_q, rgb_d;

    always_comb begin
        s1_u_d = $signed({1'b0, yuv_i[23:16]}) - OFS9;
        s1_v_d = $signed({1'b0, yuv_i[7:0]})   - OFS9;

        u_ext    = 18'(s1_u_q);
        v_ext    = 18'(s1_v_q);
        s2_pr_d  = K_RV * v_ext;
        s2_pgu_d = K_GU * u_ext;
        s2_pgv_d = K_GV * v_ext;
        s2_pb_d  = K_BU * u_ext;

        // >>> on signed operands floors, matching the reference rounding
        r_off  = (s2_pr_q + RND18) >>> SHIFT;
        g_off  = (s2_pgu_q + s2_pgv_q + RND18) >>> SHIFT;
        b_off  = (s2_pb_q + RND18) >>> SHIFT;
        y0_ext = $signed({10'b0, s2_y0_q});
        y1_ext = $signed({10'b0, s2_y1_q});
        rgb_d  = {clamp_u8(y0_ext + r_off), clamp_u8(y0_ext - g_off), clamp_u8(y0_ext + b_off),
                  clamp_u8(y1_ext + r_off), clamp_u8(y1_ext - g_off), clamp_u8(y1_ext + b_off)};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_y0_q  <= '0;
            s1_y1_q  <= '0;
            s1_u_q   <= '0;
            s1_v_q   <= '0;
            s2_y0_q  <= '0;
            s2_y1_q  <= '0;
            s2_pr_q  <= '0;
            s2_pgu_q <= '0;
            s2_pgv_q <= '0;
            s2_pb_q  <= '0;
            rgb_q    <= '0;
        end else begin
            if (stage_en_i[0]) begin
                s1_y0_q <= yuv_i[31:24];
                s1_y1_q <= yuv_i[15:8];
                s1_u_q  <= s1_u_d;
                s1_v_q  <= s1_v_d;
            end
            if (stage_en_i[1]) begin
                s2_y0_q  <= s1_y0_q;
                s2_y1_q  <= s1_y1_q;
                s2_pr_q  <= s2_pr_d;
                s2_pgu_q <= s2_pgu_d;
                s2_pgv_q <= s2_pgv_d;
                s2_pb_q  <= s2_pb_d;
            end
            if (stage_en_i[2])
                rgb_q <= rgb_d;
        end
    end

    assign rgb_o = rgb_q;

endmodule

// File: rtl/yuv422_to_rgb.sv
// -----------------------------------------------------------------------------
// yuv422_to_rgb
// Packed full-swing YUV422 to packed 8-bit RGB, PIXEL_PER_CLK pixels per beat,
// 3-stage pipeline with valid/ready back-pressure and no data loss.
// Coefficients: BT.601 by default, BT.709 when YUV422_TO_RGB_BT709_EN is defined.
// Ports:
//   clk_i        clock, rising edge
//   reset_i      asynchronous active-high reset
//   yuv_i        per pair MSB first {Y0,U0,Y1,V0},{Y2,U2,Y3,V2},...
//   yuv_valid_i  input beat valid
//   yuv_ready_o  input beat accepted this cycle when valid
//   rgb_o        MSB first {R0,G0,B0,R1,G1,B1,...}
//   rgb_valid_o  output beat valid
//   rgb_ready_i  downstream accepts output beat
// -----------------------------------------------------------------------------
module yuv422_to_rgb
    import yuv_rgb_pkg::*;
#(
    parameter int PIXEL_PER_CLK = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [PIXEL_PER_CLK*16-1:0] yuv_i,
    input  logic                        yuv_valid_i,
    output logic                        yuv_ready_o,
    output logic [PIXEL_PER_CLK*24-1:0] rgb_o,
    output logic                        rgb_valid_o,
    input  logic                        rgb_ready_i
);

    localparam int NPAIR = PIXEL_PER_CLK / 2;

    logic [2:0] vld_q, vld_d;
    logic [2:0] stage_en;
    logic       s1_free, s2_free, s3_free;

    // A stage is free when empty or when its contents move on this cycle;
    // this chains back from the output so a full pipeline shifts without a bubble.
    always_comb begin
        s3_free  = !vld_q[2] || rgb_ready_i;
        s2_free  = !vld_q[1] || s3_free;
        s1_free  = !vld_q[0] || s2_free;
        stage_en = {vld_q[1] && s3_free, vld_q[0] && s2_free, yuv_valid_i && s1_free};

        vld_d = vld_q;
        if (s1_free) vld_d[0] = yuv_valid_i;
        if (s2_free) vld_d[1] = vld_q[0];
        if (s3_free) vld_d[2] = vld_q[1];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            vld_q <= '0;
        else
            vld_q <= vld_d;
    end

    for (genvar p = 0; p < NPAIR; p++) begin : g_pair
        yuv_pair_to_rgb u_pair (
            .clk_i      (clk_i),
            .reset_i    (reset_i),
            .stage_en_i (stage_en),
            .yuv_i      (yuv_i[(NPAIR-1-p)*32 +: 32]),
            .rgb_o      (rgb_o[(NPAIR-1-p)*48 +: 48])
        );
    end

    assign yuv_ready_o = s1_free;
    assign rgb_valid_o = vld_q[2];

endmodule
